// File: rtl/swan_cart_pkg.sv
// Shared types and constants for the cartridge unlock receiver.
// Holds the FSM state encoding, the frame geometry and the SYSTEM_CTRL1 location.
package swan_cart_pkg;

  localparam int               FRAME_W   = 18;
  localparam logic [FRAME_W-1:0] FRAME_PAT = 18'b0_0010100010100000_0;

  localparam logic [7:0] ADDR_KEY  = 8'hA5;
  localparam logic [7:0] ADDR_IDLE = 8'h00;

  localparam logic [7:0] SYSCTRL1_ADDR       = 8'hA0;
  localparam int         SYSCTRL1_UNLOCK_BIT = 7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEND  = 3'd1,
    S_HUNT  = 3'd2,
    S_CAPT  = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5,
    S_FAIL  = 3'd6
  } state_t;

endpackage

// File: rtl/swan_serial_capture.sv
// LSB-first frame shifter with bit counter; the serial bit enters at the top so
// the first received bit ends up in frame[0].
module swan_serial_capture
  import swan_cart_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               en,
  input  logic               clr,
  input  logic               din,
  output logic               full,
  output logic [FRAME_W-1:0] frame
);

  localparam int CW = $clog2(FRAME_W + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      frame <= '1;
      cnt   <= '0;
    end else if (clr) begin
      frame <= '1;
      cnt   <= '0;
    end else if (en) begin
      frame <= {din, frame[FRAME_W-1:1]};
      cnt   <= cnt + 1'b1;
    end
  end

  // High when the next enabled shift completes the frame.
  assign full = (cnt == CW'(FRAME_W - 1));

endmodule

// File: rtl/swan_cart_unlock.sv
// Boot-time cartridge unlock: issues the A5 key, hunts the start bit, captures and
// checks the mapper frame. Define SWAN_UNLOCK_SYNC_EN to add a 2-flop si synchronizer.
module swan_cart_unlock
  import swan_cart_pkg::*;
#(
  parameter int TIMEOUT = 64
)(
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       si,
  output logic [7:0] addr_o,
  output logic       addr_oe,
  output logic       busy,
  output logic       ctrl_unlock,
  output logic       done,
  output logic       fail,
  output state_t     state_dbg
);

  // Handshake: start is a single-cycle request accepted only in IDLE; done is a
  // single-cycle pulse; ctrl_unlock and fail are sticky until RST.

  logic si_s;

`ifdef SWAN_UNLOCK_SYNC_EN
  localparam int HUNT_LIMIT = TIMEOUT + 2;
  logic [1:0] si_sync;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) si_sync <= 2'b11;
    else     si_sync <= {si_sync[0], si};
  end

  assign si_s = si_sync[1];
`else
  localparam int HUNT_LIMIT = TIMEOUT;
  assign si_s = si;
`endif

  state_t               state, state_n;
  logic [8:0]           tcnt;
  logic                 tcnt_clr, tcnt_inc;
  logic                 cap_en, cap_clr, cap_full;
  logic [FRAME_W-1:0]   frame;

  swan_serial_capture u_capture (
    .CLK   (CLK),
    .RST   (RST),
    .en    (cap_en),
    .clr   (cap_clr),
    .din   (si_s),
    .full  (cap_full),
    .frame (frame)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      tcnt  <= '0;
    end else begin
      state <= state_n;
      if (tcnt_clr)      tcnt <= '0;
      else if (tcnt_inc) tcnt <= tcnt + 1'b1;
    end
  end

  always_comb begin
    state_n  = state;
    cap_en   = 1'b0;
    cap_clr  = 1'b0;
    tcnt_clr = 1'b0;
    tcnt_inc = 1'b0;
    addr_o   = ADDR_IDLE;
    addr_oe  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_n = S_SEND;
      end
      S_SEND: begin
        addr_o   = ADDR_KEY;
        addr_oe  = 1'b1;
        busy     = 1'b1;
        cap_clr  = 1'b1;
        tcnt_clr = 1'b1;
        state_n  = S_HUNT;
      end
      S_HUNT: begin
        addr_oe = 1'b1;
        busy    = 1'b1;
        // The final hunt slot is the timeout itself; a start bit there is too late.
        if (tcnt == 9'(HUNT_LIMIT - 1)) begin
          state_n = S_FAIL;
        end else if (!si_s) begin
          cap_en  = 1'b1;
          state_n = S_CAPT;
        end else begin
          tcnt_inc = 1'b1;
        end
      end
      S_CAPT: begin
        addr_oe = 1'b1;
        busy    = 1'b1;
        cap_en  = 1'b1;
        if (cap_full) state_n = S_CHECK;
      end
      S_CHECK: begin
        addr_oe = 1'b1;
        busy    = 1'b1;
        if (frame == FRAME_PAT) begin
          done    = 1'b1;
          state_n = S_DONE;
        end else begin
          state_n = S_FAIL;
        end
      end
      S_DONE:  state_n = S_DONE;
      S_FAIL:  state_n = S_FAIL;
      default: state_n = S_IDLE;
    endcase
  end

  // Terminal states double as the sticky SYSTEM_CTRL1 unlock bit and fail flag.
  assign ctrl_unlock = (state == S_DONE);
  assign fail        = (state == S_FAIL);
  assign state_dbg   = state;

endmodule

// File: tb/tb_swan_cart_unlock.sv
// Directed bench for swan_cart_unlock with a behavioural mapper on si and an
// expected-result queue checked when each boot attempt resolves.
module tb_swan_cart_unlock;
  import swan_cart_pkg::*;

`ifdef SWAN_UNLOCK_SYNC_EN
  localparam int XLAT = 2;
`else
  localparam int XLAT = 0;
`endif

  localparam logic [17:0] GOOD_FRAME = 18'b0_0010100010100000_0;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start;
  logic       si;
  logic [7:0] addr_o;
  logic       addr_oe, busy, ctrl_unlock, done, fail;
  state_t     state_dbg;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [8:0] exp_q[$];

  // mapper model configuration (written by the stimulus block only)
  logic        cfg_present = 1'b0;
  logic [17:0] cfg_frame   = GOOD_FRAME;
  int          cfg_delay   = 0;
  logic        cfg_idle    = 1'b1;

  swan_cart_unlock dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .si          (si),
    .addr_o      (addr_o),
    .addr_oe     (addr_oe),
    .busy        (busy),
    .ctrl_unlock (ctrl_unlock),
    .done        (done),
    .fail        (fail),
    .state_dbg   (state_dbg)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // mapper: one-shot load on the A5 key, optional delay, then LSB-first frame
  logic m_armed, m_used;
  int   m_wait, m_idx;

  initial begin
    si = 1'b1; m_armed = 1'b0; m_used = 1'b0; m_wait = 0; m_idx = 0;
    forever begin
      @(posedge CLK);
      if (RST) begin
        m_armed = 1'b0;
        m_used  = 1'b0;
      end else if (cfg_present && !m_used && addr_oe && addr_o == 8'hA5) begin
        m_armed = 1'b1;
        m_used  = 1'b1;
        m_wait  = cfg_delay;
        m_idx   = 0;
      end
      #1;
      if (m_armed && m_wait > 0) begin
        si = 1'b1;
        m_wait--;
      end else if (m_armed && m_idx < 18) begin
        si = cfg_frame[m_idx];
        m_idx++;
      end else begin
        m_armed = 1'b0;
        si = cfg_idle;
      end
    end
  end

  // checker / driver tasks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST   = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic run_boot(input string tag, input logic ok, input int lat);
    logic [8:0] e, obs;
    int   a5, dn, lat_obs;
    logic ok_obs;
    a5 = 0; dn = 0; lat_obs = -1; ok_obs = 1'b0;
    exp_q.push_back({ok, 8'(lat)});
    @(negedge CLK);
    start = 1'b1;
    for (int cyc = 1; cyc <= 150; cyc++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (cyc == 1) start = 1'b0;
      if (addr_oe && addr_o == 8'hA5) a5++;
      if (done) begin
        dn++;
        if (lat_obs < 0) begin lat_obs = cyc; ok_obs = 1'b1; end
      end
      if (fail && lat_obs < 0) begin lat_obs = cyc; ok_obs = 1'b0; end
      if (lat_obs >= 0 && cyc >= lat_obs + 3) break;
    end
    obs = (lat_obs < 0) ? 9'h1ff : {ok_obs, 8'(lat_obs)};
    e = exp_q.pop_front();
    chk({tag, ":result_latency"}, obs, e);
    chk({tag, ":a5_cycles"}, a5, 1);
    chk({tag, ":done_pulses"}, dn, ok ? 1 : 0);
    chk({tag, ":ctrl_unlock"}, ctrl_unlock, ok);
    chk({tag, ":fail"}, fail, !ok);
    chk({tag, ":addr_oe_after"}, addr_oe, 0);
    chk({tag, ":busy_after"}, busy, 0);
  endtask

  // directed sequence
  initial begin
    int a5, oe_cnt, d;
    RST = 1'b1;
    start = 1'b0;
    #2;
    chk("reset:addr_o", addr_o, 8'h00);
    chk("reset:addr_oe", addr_oe, 0);
    chk("reset:busy", busy, 0);
    chk("reset:ctrl_unlock", ctrl_unlock, 0);
    chk("reset:done", done, 0);
    chk("reset:fail", fail, 0);
    chk("reset:state", state_dbg, S_IDLE);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // good cart
    cfg_present = 1'b1; cfg_frame = GOOD_FRAME; cfg_delay = 0; cfg_idle = 1'b1;
    run_boot("good", 1'b1, 20 + XLAT);

    // repeat start while in DONE
    a5 = 0; oe_cnt = 0;
    @(negedge CLK);
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      start = 1'b0;
      if (addr_o == 8'hA5) a5++;
      if (addr_oe) oe_cnt++;
    end
    chk("restart:a5_cycles", a5, 0);
    chk("restart:addr_oe_cycles", oe_cnt, 0);
    chk("restart:ctrl_unlock", ctrl_unlock, 1);
    chk("restart:state", state_dbg, S_DONE);

    // no cart
    do_reset();
    cfg_present = 1'b0;
    run_boot("no_cart", 1'b0, 66 + XLAT);

    // corrupt frame: bit 6 flipped 1->0
    do_reset();
    cfg_present = 1'b1;
    cfg_frame = GOOD_FRAME;
    cfg_frame[6] = 1'b0;
    run_boot("corrupt_bit6", 1'b0, 21 + XLAT);

    // late start bits
    do_reset();
    cfg_frame = GOOD_FRAME; cfg_delay = 10;
    run_boot("delay10", 1'b1, 30 + XLAT);
    do_reset();
    cfg_delay = 62 + XLAT;
    run_boot("delay_last_ok", 1'b1, 82 + XLAT + XLAT);
    do_reset();
    cfg_delay = 63 + XLAT;
    run_boot("delay_too_late", 1'b0, 66 + XLAT);

    // si stuck at 0
    do_reset();
    cfg_present = 1'b0; cfg_idle = 1'b0;
    run_boot("stuck0", 1'b0, 21 + XLAT);
    cfg_idle = 1'b1;

    // reset mid-frame, then clean re-unlock
    do_reset();
    cfg_present = 1'b1; cfg_frame = GOOD_FRAME; cfg_delay = 0;
    @(negedge CLK);
    start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      start = 1'b0;
    end
    chk("midframe:state_before", state_dbg, S_CAPT);
    RST = 1'b1;
    #1;
    chk("midframe:addr_o", addr_o, 8'h00);
    chk("midframe:addr_oe", addr_oe, 0);
    chk("midframe:busy", busy, 0);
    chk("midframe:ctrl_unlock", ctrl_unlock, 0);
    chk("midframe:done", done, 0);
    chk("midframe:fail", fail, 0);
    chk("midframe:state", state_dbg, S_IDLE);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    run_boot("rearm", 1'b1, 20 + XLAT);

    // random delays inside the window
    for (int k = 0; k < 3; k++) begin
      do_reset();
      d = $urandom_range(0, 62 + XLAT);
      cfg_delay = d;
      run_boot("rand_delay", 1'b1, 20 + XLAT + d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
